// File: rtl/tt_um_emern_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_emern_cmd_tx
// Purpose  : Host-side SPI mode-0 command transmitter. Sends one 56-bit frame
//            LSB first under CS, with SCK rising edges gated by tx_allow.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_emern_cmd_tx #(
  parameter int HALF_DIV = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [55:0] cmd_data,
  input  logic        tx_allow,
  output logic        busy,
  output logic        done,
  output logic        cs_out,
  output logic        sck_out,
  output logic        mosi_out
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [7:0] HALF_LAST  = 8'(HALF_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [5:0] LAST_BIT   = 6'd55;

  logic [2:0]  state;
  logic [7:0]  phase;
  logic [5:0]  bit_cnt;
  // Bit 0 goes straight to mosi_out on accept, so only bits 55:1 are queued.
  logic [54:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= 8'd0;
      bit_cnt   <= 6'd0;
      shreg     <= 55'd0;
      cs_out    <= 1'b1;
      sck_out   <= 1'b0;
      mosi_out  <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            shreg     <= cmd_data[55:1];
            mosi_out  <= cmd_data[0];
            cs_out    <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            phase     <= 8'd0;
            bit_cnt   <= 6'd0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase == SETUP_LAST) begin
            phase <= 8'd0;
            state <= ST_LOW;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        ST_LOW: begin
          // Phase saturates at the end of the half period; the rise then
          // waits for tx_allow with no time limit.
          if (phase == HALF_LAST) begin
            if (tx_allow) begin
              sck_out <= 1'b1;
              phase   <= 8'd0;
              state   <= ST_HIGH;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end

        ST_HIGH: begin
          if (phase == HALF_LAST) begin
            sck_out <= 1'b0;
            phase   <= 8'd0;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              mosi_out <= shreg[0];
              shreg    <= {1'b0, shreg[54:1]};
              state    <= ST_LOW;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end

        ST_HOLD: begin
          if (phase == HALF_LAST) begin
            cs_out   <= 1'b1;
            done     <= 1'b1;
            mosi_out <= 1'b0;
            phase    <= 8'd0;
            state    <= ST_GAP;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        ST_GAP: begin
          if (phase == GAP_LAST) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            phase     <= 8'd0;
            state     <= ST_IDLE;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          phase     <= 8'd0;
          cs_out    <= 1'b1;
          sck_out   <= 1'b0;
          mosi_out  <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_emern_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_emern_cmd_tx
// Purpose  : Self-checking bench for the SPI command transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_emern_cmd_tx;

  localparam int HALF_DIV = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_GAP   = 8;
  localparam int BOUND    = 3000;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [55:0] cmd_data;
  logic        tx_allow;
  logic        busy;
  logic        done;
  logic        cs_out;
  logic        sck_out;
  logic        mosi_out;

  tt_um_emern_cmd_tx #(
    .HALF_DIV(HALF_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .tx_allow (tx_allow),
    .busy     (busy),
    .done     (done),
    .cs_out   (cs_out),
    .sck_out  (sck_out),
    .mosi_out (mosi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 = no stall, 1 = tx_allow low after the fall that presents stall_bit,
  // 2 = tx_allow low right after the rise that samples stall_bit.
  typedef struct {
    logic [55:0] data;
    int          mode;
    int          stall_bit;
    int          stall_len;
    int          exp_len;
  } vec_t;

  vec_t vecs[4];

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, refreshed once per falling clk edge.
  logic [55:0] cap;
  int          rise_cnt;
  int          done_cnt;
  int          proto_viol;
  int          width_viol;
  int          hi_run;
  logic        prev_sck;
  logic        prev_mosi;
  int          last_len;
  int          cs_rise_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap        = '0;
    rise_cnt   = 0;
    done_cnt   = 0;
    proto_viol = 0;
    width_viol = 0;
    hi_run     = 0;
    prev_sck   = sck_out;
    prev_mosi  = mosi_out;
  endtask

  task automatic mon_cycle();
    if (sck_out && !prev_sck) begin
      if (rise_cnt < 56) cap[rise_cnt] = mosi_out;
      rise_cnt++;
    end
    if (!sck_out && prev_sck && hi_run != HALF_DIV) width_viol++;
    hi_run = sck_out ? hi_run + 1 : 0;
    if (sck_out && cs_out) proto_viol++;
    if (sck_out && prev_sck && mosi_out !== prev_mosi) proto_viol++;
    if (done) done_cnt++;
    prev_sck  = sck_out;
    prev_mosi = mosi_out;
  endtask

  // Waits for cmd_ready, presents d and lets it be accepted on the next rising edge.
  task automatic accept(input logic [55:0] d, input bit hold, input logic [55:0] nxt);
    int g;
    g = 0;
    while (!cmd_ready && g < BOUND) begin
      @(negedge clk);
      g++;
    end
    if (g >= BOUND) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk);
    #1;
    if (hold) cmd_data = nxt;
    else begin
      cmd_valid = 1'b0;
      cmd_data  = '0;
    end
    check("accept_busy",  busy,      1'b1);
    check("accept_ready", cmd_ready, 1'b0);
    check("accept_cs",    cs_out,    1'b0);
    check("accept_mosi0", mosi_out,  d[0]);
  endtask

  // Follows a frame from the accept edge until cmd_ready returns.
  // last_len counts from the accept edge to the earliest next accept edge.
  task automatic watch_frame(input vec_t v, input string tag);
    int   len;
    int   stall_left;
    int   stall_viol;
    bit   started;
    bit   ok;
    logic prev_cs;
    clear_mon();
    len         = 0;
    stall_left  = 0;
    stall_viol  = 0;
    started     = 1'b0;
    ok          = 1'b0;
    prev_cs     = cs_out;
    cs_rise_len = -1;
    while (len < BOUND) begin
      @(negedge clk);
      len++;
      mon_cycle();
      if (cs_out && !prev_cs && cs_rise_len < 0) cs_rise_len = len;
      prev_cs = cs_out;
      if (stall_left > 0) begin
        if (v.mode == 1 && (sck_out || mosi_out !== v.data[v.stall_bit])) stall_viol++;
        stall_left--;
        if (stall_left == 0) tx_allow = 1'b1;
      end
      if (!started && v.mode == 1 && rise_cnt == v.stall_bit && !sck_out && !cs_out) begin
        started    = 1'b1;
        tx_allow   = 1'b0;
        stall_left = v.stall_len;
      end
      if (!started && v.mode == 2 && rise_cnt == v.stall_bit + 1 && sck_out) begin
        started    = 1'b1;
        tx_allow   = 1'b0;
        stall_left = v.stall_len;
      end
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tx_allow = 1'b1;
    last_len = len;
    check({tag, "_completed"},  ok,         1'b1);
    check({tag, "_period"},     len,        v.exp_len);
    check({tag, "_rises"},      rise_cnt,   56);
    check({tag, "_data"},       cap,        v.data);
    check({tag, "_done_count"}, done_cnt,   1);
    check({tag, "_protocol"},   proto_viol, 0);
    check({tag, "_high_width"}, width_viol, 0);
    check({tag, "_busy_end"},   busy,       1'b0);
    check({tag, "_cs_end"},     cs_out,     1'b1);
    if (v.mode != 0) check({tag, "_stall_seen"}, started, 1'b1);
    if (v.mode == 1) check({tag, "_stall_hold"}, stall_viol, 0);
  endtask

  initial begin
    vec_t va;
    vec_t vb;
    int   g;

    // Unstalled frame: 1 + 4 + 56*2*4 + 4 + 8 = 465 cycles.
    vecs[0] = '{56'h00_0000_0000_0021, 0, 0,  0,  465};
    // 50-cycle stall from the start of bit 20's LOW: rise moves from +4 to +51.
    vecs[1] = '{56'hA5_5A_F0_0F_C3_3C_81, 1, 20, 50, 512};
    // Drop during bit 10's HIGH for 10 cycles: next rise moves from +8 to +11.
    vecs[2] = '{56'hFF_FFFF_FFFF_FFFF, 2, 10, 10, 468};
    vecs[3] = '{56'h80_0000_0000_0001, 0, 0,  0,  465};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    tx_allow  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cs",    cs_out,    1'b1);
    check("reset_sck",   sck_out,   1'b0);
    check("reset_mosi",  mosi_out,  1'b0);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_busy",  busy,      1'b0);
    check("reset_done",  done,      1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      accept(vecs[i].data, 1'b0, '0);
      watch_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with cmd_valid held: the second accept follows the CS rise
    // after the CS_GAP cycles plus the idle accept cycle.
    va = '{56'h12_3456_789A_BC80, 0, 0, 0, 465};
    vb = '{56'h0F_EDCB_A987_6581, 0, 0, 0, 465};
    accept(va.data, 1'b1, vb.data);
    watch_frame(va, "b2b_a");
    check("b2b_valid_held", cmd_valid, 1'b1);
    check("b2b_accept_gap", last_len + 1 - cs_rise_len, CS_GAP + 1);
    accept(vb.data, 1'b0, '0);
    watch_frame(vb, "b2b_b");

    // Reset at bit 30 aborts with idle outputs and no done pulse.
    accept(56'hC0_FFEE_1234_5678, 1'b0, '0);
    clear_mon();
    g = 0;
    while (!(rise_cnt == 30 && !sck_out) && g < BOUND) begin
      @(negedge clk);
      mon_cycle();
      g++;
    end
    check("abort_reached_bit30", rise_cnt, 30);
    check("abort_cs_low_before", cs_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_cs",    cs_out,    1'b1);
    check("abort_sck",   sck_out,   1'b0);
    check("abort_mosi",  mosi_out,  1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_busy",  busy,      1'b0);
    check("abort_done",  done,      1'b0);
    @(negedge clk);
    check("abort_done_count", done_cnt + int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    accept(vecs[3].data, 1'b0, '0);
    watch_frame(vecs[3], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
